sc_frame_scheduler: RTL and testbench
=====================================

Name: sc_frame_scheduler

Overview:
- Shares one successive-cancellation decoder core among N_REQ frame sources.
- Arbitrates round-robin among pending sources and loads the winner's channel-LLR frame into the decoder.
- Sequences the decoder's en/valid/busy/done protocol and returns the decoded word tagged with the source id through a valid/ready result port.
- A watchdog aborts a decode that never completes.

Parameters:
- N_REQ, 4, number of frame sources (≥2)
- n, 5, log2 of code length N = 2**n
- Q, 6, LLR width in bits (sign-magnitude)
- TIMEOUT, 1023, maximum cycles spent in WAIT_BUSY+DECODE before abort (≥2)
- IDW (localparam), $clog2(N_REQ), id width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  N_REQ  bit i: source i presents a frame
- req_llr  in  N_REQ*(2**n)*Q  source i frame at slice [i*(2**n)*Q +: (2**n)*Q]
- req_ready  out  N_REQ  one-hot accept; frame i transferred when req_valid[i]&req_ready[i]
- dec_en  out  1  decoder enable
- dec_llr  out  (2**n)*Q  frame to decoder channel_LLR_in
- dec_llr_valid  out  1  one-cycle load strobe to decoder
- dec_busy  in  1  decoder busy
- dec_done  in  1  decoder done pulse; dec_code valid in same cycle
- dec_code  in  2**n  decoded word
- res_valid  out  1  result available
- res_id  out  IDW  source id of result
- res_code  out  2**n  decoded word
- res_ready  in  1  consumer accepts result
- timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset (rst_n=0 at a clk edge, any state, including mid-decode) forces:
  - state IDLE; all outputs 0; frame register, res_id, res_code and watchdog counter 0
  - rr_ptr = N_REQ-1, so source 0 has top priority after reset
- FSM states: IDLE, LOAD, WAIT_BUSY, DECODE, RESULT.
- IDLE:
  - Winner g = first i with req_valid[i]=1, searching (rr_ptr+1) mod N_REQ upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other bits 0. req_ready is 0 in every other state.
  - On accept: latch req_llr slice g into the frame register, set id_reg=g and rr_ptr=g, go to LOAD.
  - If no req_valid, remain in IDLE. A source may drop req_valid before it is granted.
- LOAD (exactly 1 cycle): dec_llr_valid=1, dec_en=1, dec_llr=frame register, watchdog cleared; go to WAIT_BUSY.
- dec_llr is held at the frame register in all states. dec_en=1 in LOAD, WAIT_BUSY and DECODE, 0 otherwise.
- WAIT_BUSY:
  - dec_busy=1 → DECODE.
  - dec_done=1 (busy never seen) is treated as completion, as in DECODE.
- DECODE: dec_done=1 → capture res_code=dec_code and res_id=id_reg, go to RESULT.
- Watchdog:
  - Increments every cycle in WAIT_BUSY/DECODE.
  - On reaching TIMEOUT without dec_done: timeout_err=1 for one cycle, dec_en=0 next cycle, go to IDLE.
  - The frame is dropped, no result is produced, and rr_ptr keeps g.
  - If dec_done and the timeout coincide, dec_done wins and no error is raised.
- RESULT:
  - res_valid=1; res_id and res_code are stable until the handshake.
  - res_valid&res_ready → res_valid=0 next cycle, state IDLE.
  - res_ready may already be high on the first RESULT cycle, so minimum occupancy is 1 cycle.
  - No new frame is accepted while a result is pending (single-frame pipeline, no overlap).
- Latency:
  - Accept cycle T → dec_llr_valid at T+1.
  - dec_done at cycle D → res_valid at D+1.
  - Handshake at H → earliest next accept at H+1.
- Fairness: a source continuously requesting is served at least once every N_REQ frames.

Test Plan:
- Reset then req_valid=4'b0001, source 0 frame all LLR=+5 → req_ready=0001 at T, dec_llr_valid at T+1, dec_en high until done. Model decoder done after 40 cycles with code 32'hA5A5_0F0F → res_valid, res_id=0, res_code=32'hA5A5_0F0F.
- req_valid=4'b1111 held, res_ready=1 → grant order 0,1,2,3,0; each res_id matches the grant.
- After source 2 is served, req_valid=4'b0101 → source 0 granted next (wrap from rr_ptr=2), then 2.
- Decoder model never asserts dec_done, TIMEOUT=1023 → timeout_err pulses exactly 1023 cycles after LOAD; dec_en=0; no res_valid; next request is accepted.
- res_ready=0 for 20 cycles in RESULT with req_valid=4'b0010 → req_ready stays 0 and res_id/res_code stable. Then res_ready=1 → source 1 accepted the cycle after the handshake.
- rst_n=0 for 1 cycle during DECODE → next cycle all outputs 0 and state IDLE; the late dec_done after reset is ignored and no res_valid is produced.

Source files
------------

// File: rtl/sc_frame_scheduler.sv
// sc_frame_scheduler: round-robin sharing of one SC decoder core among N_REQ frame sources
module sc_frame_scheduler #(
    parameter  int N_REQ   = 4,
    parameter  int n       = 5,
    parameter  int Q       = 6,
    parameter  int TIMEOUT = 1023,
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*(2**n)*Q-1:0]   req_llr,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        dec_en,
    output logic [(2**n)*Q-1:0]         dec_llr,
    output logic                        dec_llr_valid,
    input  logic                        dec_busy,
    input  logic                        dec_done,
    input  logic [2**n-1:0]             dec_code,
    output logic                        res_valid,
    output logic [IDW-1:0]              res_id,
    output logic [2**n-1:0]             res_code,
    input  logic                        res_ready,
    output logic                        timeout_err
);
    localparam int FW = (2**n) * Q;
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, DECODE, RESULT} state_t;
    state_t          state;
    logic [FW-1:0]   frame;
    logic [IDW-1:0]  rr_ptr, gnt, idx;
    logic            found;
    logic [CW-1:0]   wd;
    assign dec_llr   = frame;
    assign req_ready = (state == IDLE && found) ? N_REQ'(1) << gnt : '0;
    // rotating-priority search beginning just after the last winner
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end
    // FSM with registered outputs; wd counts WAIT_BUSY/DECODE cycles so that
    // the abort lands timeout_err exactly TIMEOUT cycles after LOAD; rr_ptr
    // doubles as the id of the frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            frame         <= '0;
            rr_ptr        <= IDW'(N_REQ - 1);
            wd            <= '0;
            dec_en        <= 1'b0;
            dec_llr_valid <= 1'b0;
            res_valid     <= 1'b0;
            res_id        <= '0;
            res_code      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_err <= 1'b0;
                    if (found) begin
                        frame         <= req_llr[int'(gnt)*FW +: FW];
                        rr_ptr        <= gnt;
                        dec_en        <= 1'b1;
                        dec_llr_valid <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    dec_llr_valid <= 1'b0;
                    wd            <= '0;
                    state         <= WAIT_BUSY;
                end
                WAIT_BUSY, DECODE: begin
                    if (dec_done) begin
                        res_code  <= dec_code;
                        res_id    <= rr_ptr;
                        res_valid <= 1'b1;
                        dec_en    <= 1'b0;
                        state     <= RESULT;
                    end else if (wd == CW'(TIMEOUT - 2)) begin
                        timeout_err <= 1'b1;
                        dec_en      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                        if (state == WAIT_BUSY && dec_busy) state <= DECODE;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_frame_scheduler.sv
// tb_sc_frame_scheduler: directed and randomized frames against a round-robin reference model
module tb_sc_frame_scheduler;
    localparam int N_REQ   = 4;
    localparam int NN      = 5;
    localparam int Q       = 6;
    localparam int TIMEOUT = 1023;
    localparam int N       = 2**NN;
    localparam int FW      = N * Q;
    localparam int IDW     = $clog2(N_REQ);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*FW-1:0]     req_llr;
    logic [N_REQ-1:0]        req_ready;
    logic                    dec_en;
    logic [FW-1:0]           dec_llr;
    logic                    dec_llr_valid;
    logic                    dec_busy;
    logic                    dec_done;
    logic [N-1:0]            dec_code;
    logic                    res_valid;
    logic [IDW-1:0]          res_id;
    logic [N-1:0]            res_code;
    logic                    res_ready;
    logic                    timeout_err;

    int vectors = 0;
    int miscompares = 0;
    int last = N_REQ - 1;

    sc_frame_scheduler #(.N_REQ(N_REQ), .n(NN), .Q(Q), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_llr(req_llr), .req_ready(req_ready),
        .dec_en(dec_en), .dec_llr(dec_llr), .dec_llr_valid(dec_llr_valid),
        .dec_busy(dec_busy), .dec_done(dec_done), .dec_code(dec_code),
        .res_valid(res_valid), .res_id(res_id), .res_code(res_code),
        .res_ready(res_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // next source after the previous winner, wrapping, that is requesting
    function automatic int winner(input logic [N_REQ-1:0] m);
        for (int k = 1; k <= N_REQ; k++)
            if (m[(last + k) % N_REQ]) return (last + k) % N_REQ;
        return -1;
    endfunction

    task automatic fill_llr();
        for (int i = 0; i < N_REQ * N; i++) req_llr[i*Q +: Q] = Q'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req_ready"}, FW'(req_ready), FW'(0));
        chk({tag, " dec_en"}, FW'(dec_en), FW'(0));
        chk({tag, " dec_llr_valid"}, FW'(dec_llr_valid), FW'(0));
        chk({tag, " dec_llr"}, dec_llr, FW'(0));
        chk({tag, " res_valid"}, FW'(res_valid), FW'(0));
        chk({tag, " res_id"}, FW'(res_id), FW'(0));
        chk({tag, " res_code"}, FW'(res_code), FW'(0));
        chk({tag, " timeout_err"}, FW'(timeout_err), FW'(0));
    endtask

    // one full frame: grant, load, bc busy cycles, done, result held for hold cycles, handshake
    task automatic frame(input logic [N_REQ-1:0] mask, input bit fill, input int bc,
                         input logic [N-1:0] code, input int hold);
        int g;
        logic [FW-1:0] f;
        @(negedge clk);
        if (fill) fill_llr();
        req_valid = mask;
        res_ready = 1'b0;
        #1;
        g = winner(mask);
        chk("idle res_valid", FW'(res_valid), FW'(0));
        chk("grant", FW'(req_ready), FW'(N_REQ'(1) << g));
        f = req_llr[g*FW +: FW];
        @(negedge clk); #1;
        chk("load strobe", FW'(dec_llr_valid), FW'(1));
        chk("load dec_en", FW'(dec_en), FW'(1));
        chk("load dec_llr", dec_llr, f);
        chk("load req_ready", FW'(req_ready), FW'(0));
        last = g;
        for (int i = 0; i < bc; i++) begin
            @(negedge clk);
            dec_busy = 1'b1;
            #1;
            chk("busy dec_en", FW'(dec_en), FW'(1));
        end
        @(negedge clk);
        dec_busy = 1'b0;
        dec_done = 1'b1;
        dec_code = code;
        #1;
        chk("done strobe low", FW'(dec_llr_valid), FW'(0));
        chk("done res_valid", FW'(res_valid), FW'(0));
        @(negedge clk);
        dec_done = 1'b0;
        dec_code = N'($urandom);
        #1;
        chk("res_valid", FW'(res_valid), FW'(1));
        chk("res_id", FW'(res_id), FW'(g));
        chk("res_code", FW'(res_code), FW'(code));
        chk("result dec_en", FW'(dec_en), FW'(0));
        chk("result req_ready", FW'(req_ready), FW'(0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk("hold res_valid", FW'(res_valid), FW'(1));
            chk("hold res_id", FW'(res_id), FW'(g));
            chk("hold res_code", FW'(res_code), FW'(code));
            chk("hold req_ready", FW'(req_ready), FW'(0));
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        chk("handshake res_valid", FW'(res_valid), FW'(1));
    endtask

    // decoder never finishes: expect abort TIMEOUT cycles after LOAD
    task automatic timeout_frame(input logic [N_REQ-1:0] mask);
        int g, tk, bad;
        @(negedge clk);
        fill_llr();
        req_valid = mask;
        res_ready = 1'b0;
        #1;
        g = winner(mask);
        chk("to grant", FW'(req_ready), FW'(N_REQ'(1) << g));
        @(negedge clk);
        req_valid = '0;
        dec_busy = 1'b1;
        #1;
        chk("to load strobe", FW'(dec_llr_valid), FW'(1));
        last = g;
        tk = 0;
        bad = 0;
        while (tk < TIMEOUT + 10) begin
            @(negedge clk); #1;
            tk++;
            if (timeout_err) break;
            if (dec_en !== 1'b1 || res_valid !== 1'b0) bad++;
        end
        chk("timeout latency", FW'(tk), FW'(TIMEOUT));
        chk("timeout run", FW'(bad), FW'(0));
        chk("timeout dec_en", FW'(dec_en), FW'(0));
        chk("timeout res_valid", FW'(res_valid), FW'(0));
        @(negedge clk);
        dec_busy = 1'b0;
        #1;
        chk("timeout pulse width", FW'(timeout_err), FW'(0));
        chk("timeout no result", FW'(res_valid), FW'(0));
    endtask

    // reset mid-decode, then a late dec_done must be ignored
    task automatic reset_mid(input logic [N_REQ-1:0] mask);
        int g;
        @(negedge clk);
        fill_llr();
        req_valid = mask;
        res_ready = 1'b0;
        #1;
        g = winner(mask);
        chk("rst grant", FW'(req_ready), FW'(N_REQ'(1) << g));
        @(negedge clk);
        req_valid = '0;
        dec_busy = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dec_busy = 1'b0;
        dec_done = 1'b1;
        dec_code = N'($urandom);
        #1;
        chk_zero("mid reset");
        @(negedge clk);
        dec_done = 1'b0;
        #1;
        chk("late done res_valid", FW'(res_valid), FW'(0));
        chk("late done dec_en", FW'(dec_en), FW'(0));
        last = N_REQ - 1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_llr = '0;
        dec_busy = 1'b0;
        dec_done = 1'b0;
        dec_code = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < N_REQ * N; i++) req_llr[i*Q +: Q] = Q'(5);
        frame(4'b0001, 1'b0, 39, 32'hA5A5_0F0F, 0);
        for (int i = 0; i < 5; i++) frame(4'b1111, 1'b1, $urandom_range(0, 6), N'($urandom), 0);
        frame(4'b0100, 1'b1, 3, N'($urandom), 0);
        frame(4'b0101, 1'b1, 0, N'($urandom), 1);
        frame(4'b0101, 1'b1, 2, N'($urandom), 0);
        timeout_frame(4'b1000);
        frame(4'b1001, 1'b1, 4, N'($urandom), 0);
        frame(4'b0010, 1'b1, 5, N'($urandom), 20);
        frame(4'b0010, 1'b1, 1, N'($urandom), 0);
        reset_mid(4'b0100);
        frame(4'b1111, 1'b1, 2, N'($urandom), 0);
        for (int i = 0; i < 12; i++)
            frame(N_REQ'($urandom_range(1, 2**N_REQ - 1)), 1'b1, $urandom_range(0, 10),
                  N'($urandom), $urandom_range(0, 3));
        @(negedge clk);
        res_ready = 1'b0;
        req_valid = '0;
        #1;
        chk("final res_valid", FW'(res_valid), FW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
